// File: rtl/mult_hilo_unit.sv
// rtl/mult_hilo_unit.sv - sequential shift-add 32x32 multiplier with HI/LO result registers
module mult_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] result_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_shift;
    logic [2*WIDTH-1:0] product;
    logic               last_iter;
    logic               mt_allowed;

    // Signed operands are reduced to magnitudes; the most negative value stays
    // as-is and is then read as an unsigned magnitude, which is exactly right.
    assign mag_a = (is_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    assign mag_b = (is_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;

    assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    assign acc_shift = {sum, acc[WIDTH-1:1]};
    assign product   = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    assign last_iter = (cnt == CNT_W'(WIDTH-1));
    assign mt_allowed = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_iter) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_shift;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_FIX);
        end
    end

    // FIX and the mthi/mtlo window are mutually exclusive states, so no priority clash.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == S_FIX) begin
            hi_q <= product[2*WIDTH-1:WIDTH];
            lo_q <= product[WIDTH-1:0];
        end else if (mt_allowed) begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
        end
    end

    assign busy       = (state == S_RUN) || (state == S_FIX);
    assign done       = done_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign result_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// tb/tb_mult_hilo_unit.sv - self-checking bench for mult_hilo_unit against an arithmetic reference
module tb_mult_hilo_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        hilo_sel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .is_signed  (is_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .wdata      (wdata),
        .hilo_sel   (hilo_sel),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .result_out (result_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
        check({tag, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
        hilo_sel = 1'b0;
        #1;
        check({tag, "_res_lo"}, {32'b0, result_out}, {32'b0, exp_lo});
        hilo_sel = 1'b1;
        #1;
        check({tag, "_res_hi"}, {32'b0, result_out}, {32'b0, exp_hi});
    endtask

    // mode 0: plain run, 1: extra start mid-run, 2: mthi mid-run
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit s, input logic [63:0] prod, input int mode);
        logic [31:0] h0;
        logic [31:0] l0;
        int done_cyc;
        int ndone;
        bit busy_ok;
        bit hold_ok;
        h0 = exp_hi;
        l0 = exp_lo;
        done_cyc = -1;
        ndone = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        is_signed = s;
        op_a = a;
        op_b = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            mthi = 1'b0;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (busy !== (k <= 32)) busy_ok = 1'b0;
            if (k <= 32 && (hi !== h0 || lo !== l0)) hold_ok = 1'b0;
            if (mode == 1 && k == 10) begin
                start = 1'b1;
                is_signed = 1'($urandom);
                op_a = $urandom;
                op_b = $urandom;
            end
            if (mode == 2 && k == 10) begin
                mthi = 1'b1;
                wdata = 32'h12345678;
            end
            if (mode != 1 && done_cyc >= 0) break;
        end
        check({tag, "_done_latency"}, 64'(done_cyc), 64'd33);
        check({tag, "_done_count"}, 64'(ndone), 64'd1);
        check({tag, "_busy_window"}, {63'b0, busy_ok}, 64'd1);
        check({tag, "_hilo_held"}, {63'b0, hold_ok}, 64'd1);
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
        check_regs(tag);
    endtask

    task automatic mt_write(input string tag, input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clk);
        mthi = wh;
        mtlo = wl;
        wdata = d;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        if (wh) exp_hi = d;
        if (wl) exp_lo = d;
        check_regs(tag);
    endtask

    task automatic reset_mid_run();
        int ndone;
        @(negedge clk);
        start = 1'b1;
        is_signed = 1'b0;
        op_a = 32'hDEADBEEF;
        op_b = 32'h01234567;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("rst_mid_busy", {63'b0, busy}, 64'd0);
        check("rst_mid_done", {63'b0, done}, 64'd0);
        check_regs("rst_mid");
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst_mid_no_done", 64'(ndone), 64'd0);
    endtask

    logic [31:0] da [6];
    logic [31:0] db [6];
    bit          ds [6];
    logic [63:0] dp [6];

    initial begin
        da[0] = 32'h00000003; db[0] = 32'h00000005; ds[0] = 1'b0; dp[0] = 64'h00000000_0000000F;
        da[1] = 32'hFFFFFFFD; db[1] = 32'h00000005; ds[1] = 1'b1; dp[1] = 64'hFFFFFFFF_FFFFFFF1;
        da[2] = 32'hFFFFFFFD; db[2] = 32'h00000005; ds[2] = 1'b0; dp[2] = 64'h00000004_FFFFFFF1;
        da[3] = 32'hFFFFFFFF; db[3] = 32'hFFFFFFFF; ds[3] = 1'b0; dp[3] = 64'hFFFFFFFE_00000001;
        da[4] = 32'h80000000; db[4] = 32'h80000000; ds[4] = 1'b1; dp[4] = 64'h40000000_00000000;
        da[5] = 32'h80000000; db[5] = 32'h00000001; ds[5] = 1'b1; dp[5] = 64'hFFFFFFFF_80000000;

        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        op_a = '0;
        op_b = '0;
        mthi = 1'b0;
        mtlo = 1'b0;
        wdata = '0;
        hilo_sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check_regs("reset");

        for (int i = 0; i < 6; i++) begin
            run_mul($sformatf("dir%0d", i), da[i], db[i], ds[i], dp[i], 0);
        end

        begin
            logic [31:0] a;
            logic [31:0] b;
            bit s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            run_mul("second_start", a, b, s, ref_prod(a, b, s), 1);
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            run_mul("mthi_busy", a, b, s, ref_prod(a, b, s), 2);
            check("mthi_busy_hi", {32'b0, hi}, {32'b0, ref_prod(a, b, s) >> 32});
        end

        mt_write("mthi_idle", 1'b1, 1'b0, 32'h12345678);
        mt_write("mtlo_idle", 1'b0, 1'b1, 32'hCAFEF00D);
        mt_write("mthilo_idle", 1'b1, 1'b1, 32'h0BADBEEF);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            if (i == 0) b = 32'hFFFFFFFF;
            if (i == 1) a = 32'h00000000;
            run_mul($sformatf("rnd%0d", i), a, b, s, ref_prod(a, b, s), 0);
        end

        reset_mid_run();
        run_mul("after_reset", 32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1,
                ref_prod(32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
